// File: rtl/lynxTypes.sv
// Shared request descriptor and sizing constants for the request path.
package lynxTypes;

  localparam int unsigned VADDR_BITS = 48;
  localparam int unsigned LEN_BITS   = 28;
  localparam int unsigned PMTU_BYTES = 4096;

  typedef struct packed {
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
    logic                  stream;
    logic                  sync;
    logic                  ctl;
    logic                  host;
    logic [3:0]            dest;
    logic [5:0]            pid;
    logic                  vfid;
    logic [4:0]            rsrvd;
  } req_t;

endpackage

// File: rtl/req_pmtu_split.sv
// Splits one request into chunks that never cross a PMTU_BYTES-aligned boundary.
module req_pmtu_split
  import lynxTypes::*;
#(
  parameter int unsigned PMTU_BYTES     = lynxTypes::PMTU_BYTES,
  parameter bit          SPLIT_CTL_LAST = 1'b1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic s_req_valid,
  output logic s_req_ready,
  input  req_t s_req_data,
  output logic m_req_valid,
  input  logic m_req_ready,
  output req_t m_req_data,
  output logic m_req_last
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  localparam logic [LEN_BITS-1:0] PMTU_L    = LEN_BITS'(PMTU_BYTES);
  localparam logic [LEN_BITS-1:0] PMTU_MASK = PMTU_L - 1'b1;

  // Bytes left before the next PMTU boundary, clipped to what remains.
  function automatic logic [LEN_BITS-1:0] chunk_len(input logic [VADDR_BITS-1:0] addr,
                                                     input logic [LEN_BITS-1:0]   rem);
    logic [LEN_BITS-1:0] room;
    room = PMTU_L - (addr[LEN_BITS-1:0] & PMTU_MASK);
    return (rem < room) ? rem : room;
  endfunction

  logic [0:0]            state_p0;
  logic                  rdy_p0;
  logic [VADDR_BITS-1:0] addr_p0;
  logic [LEN_BITS-1:0]   rem_p0;
  req_t                  req_p0;
  logic [LEN_BITS-1:0]   chunk;
  logic                  last;

  assign chunk = chunk_len(addr_p0, rem_p0);
  assign last  = (chunk == rem_p0);

  // Stage p0: request capture and per-chunk address/length advance
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_p0 <= IDLE;
      rdy_p0   <= 1'b0;
      addr_p0  <= '0;
      rem_p0   <= '0;
      req_p0   <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (s_req_valid && rdy_p0) begin
            state_p0 <= SPLIT;
            rdy_p0   <= 1'b0;
            addr_p0  <= s_req_data.vaddr;
            rem_p0   <= s_req_data.len;
            req_p0   <= s_req_data;
          end else begin
            rdy_p0 <= 1'b1;
          end
        end
        default: begin
          if (m_req_ready) begin
            if (last) begin
              state_p0 <= IDLE;
              rdy_p0   <= 1'b1;
            end else begin
              addr_p0 <= addr_p0 + VADDR_BITS'(chunk);
              rem_p0  <= rem_p0 - chunk;
            end
          end
        end
      endcase
    end
  end

  assign s_req_ready = rdy_p0;
  assign m_req_valid = (state_p0 == SPLIT);
  assign m_req_last  = (state_p0 == SPLIT) && last;

  // Output view is derived only from registers, so it is stable under back-pressure.
  always_comb begin
    m_req_data       = req_p0;
    m_req_data.vaddr = addr_p0;
    m_req_data.len   = chunk;
    m_req_data.ctl   = SPLIT_CTL_LAST ? (req_p0.ctl && m_req_last) : req_p0.ctl;
  end

endmodule

// File: tb/tb_req_pmtu_split.sv
// Randomised scenario bench for req_pmtu_split against a chunk-list reference model.
module tb_req_pmtu_split;
  import lynxTypes::*;

  localparam longint unsigned P      = 4096;
  localparam longint unsigned MASK48 = 64'hFFFF_FFFF_FFFF;

  logic aclk = 1'b0;
  logic aresetn;
  logic s_req_valid;
  logic s_req_ready;
  req_t s_req_data;
  logic m_req_valid;
  logic m_req_ready;
  req_t m_req_data;
  logic m_req_last;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    req_t data;
    logic last;
  } exp_t;

  req_pmtu_split #(.PMTU_BYTES(4096), .SPLIT_CTL_LAST(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
    .m_req_last(m_req_last)
  );

  always #5 aclk = ~aclk;

  function automatic req_t rand_req(input logic [47:0] va, input logic [27:0] ln);
    req_t r;
    r        = req_t'({$urandom(), $urandom(), $urandom()});
    r.vaddr  = va;
    r.len    = ln;
    return r;
  endfunction

  task automatic send_req(input req_t rq, input string tag);
    int cyc = 0;
    s_req_data  = rq;
    s_req_valid = 1'b1;
    while (!s_req_ready && cyc < 20) begin
      @(negedge aclk);
      cyc++;
    end
    n_cmp++;
    if (s_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: s_req_ready=%b required 1 within 20 cycles", tag, s_req_ready);
      s_req_valid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    s_req_valid = 1'b0;
    s_req_data  = req_t'({$urandom(), $urandom(), $urandom()});
    @(negedge aclk);
    n_cmp++;
    if (m_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: m_req_valid=%b required 1 one cycle after accept", tag, m_req_valid);
    end
  endtask

  // Consumes up to max_chunks chunks of rq, comparing each cycle with the reference list.
  task automatic drain(input req_t rq, input int rdy_pct, input int stall_idx,
                       input int stall_n, input int max_chunks, input string tag);
    exp_t q[$];
    exp_t e;
    longint unsigned a, r, room, c;
    int n, cyc;
    logic rdy;
    a = rq.vaddr;
    r = rq.len;
    do begin
      room = P - (a % P);
      c = (r < room) ? r : room;
      e.data       = rq;
      e.data.vaddr = a[47:0];
      e.data.len   = c[27:0];
      e.last       = (c == r);
      e.data.ctl   = rq.ctl & e.last;
      q.push_back(e);
      a = (a + c) & MASK48;
      r = r - c;
    end while (r != 0);
    n = (max_chunks < q.size()) ? max_chunks : q.size();
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      forever begin
        n_cmp++;
        if (m_req_valid !== 1'b1 || m_req_data !== q[i].data || m_req_last !== q[i].last) begin
          n_fail++;
          $display("FAIL %s_chunk%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b", tag, i,
                   m_req_valid, m_req_data, m_req_last, q[i].data, q[i].last);
        end
        if (i == stall_idx && cyc < stall_n) rdy = 1'b0;
        else rdy = ($urandom_range(99) < rdy_pct);
        m_req_ready = rdy;
        @(negedge aclk);
        cyc++;
        if (rdy) break;
        if (cyc > 200) begin
          n_fail++;
          $display("FAIL %s_timeout: chunk %0d never accepted", tag, i);
          m_req_ready = 1'b0;
          return;
        end
      end
    end
    m_req_ready = 1'b0;
    if (n == q.size()) begin
      n_cmp++;
      if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_end: m_req_valid=%b s_req_ready=%b required 0 and 1", tag,
                 m_req_valid, s_req_ready);
      end
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0; s_req_valid = 1'b0; m_req_ready = 1'b0; s_req_data = '0;
    repeat (3) @(negedge aclk);
    n_cmp++;
    if (s_req_ready !== 1'b0 || m_req_valid !== 1'b0 || m_req_last !== 1'b0 || m_req_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b v=%b l=%b d=%h required all 0", s_req_ready,
               m_req_valid, m_req_last, m_req_data);
    end
    aresetn = 1'b1;
    #1;
    n_cmp++;
    if (s_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: s_req_ready=%b required 0 before first edge", s_req_ready);
    end
    @(negedge aclk);
    n_cmp++;
    if (s_req_ready !== 1'b1 || m_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge: rdy=%b v=%b required 1 and 0", s_req_ready, m_req_valid);
    end
  endtask

  task automatic test_boundaries;
    req_t rq;
    rq = rand_req(48'h1000, 28'd8192);
    rq.ctl = 1'b1;
    send_req(rq, "aligned2");
    drain(rq, 100, -1, 0, 99, "aligned2");
    rq = rand_req(48'h0F00, 28'h300);
    send_req(rq, "straddle");
    drain(rq, 100, -1, 0, 99, "straddle");
    rq = rand_req(48'h10, 28'd0);
    send_req(rq, "zero_len");
    drain(rq, 100, -1, 0, 99, "zero_len");
    rq = rand_req(48'hFFFF_FFFF_FF80, 28'd300);
    send_req(rq, "wrap48");
    drain(rq, 70, -1, 0, 99, "wrap48");
    rq = rand_req(48'h2345, 28'd1);
    send_req(rq, "one_byte");
    drain(rq, 100, -1, 0, 99, "one_byte");
  endtask

  task automatic test_stall;
    req_t rq;
    rq = rand_req(48'h0, 28'd12288);
    send_req(rq, "stall");
    drain(rq, 100, 1, 5, 99, "stall");
  endtask

  task automatic test_reset_mid;
    req_t rq;
    rq = rand_req(48'h0, 28'd12288);
    send_req(rq, "rst_mid");
    drain(rq, 100, -1, 0, 1, "rst_mid");
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if (m_req_valid !== 1'b0 || m_req_last !== 1'b0 || m_req_data !== '0 || s_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: v=%b l=%b d=%h rdy=%b required all 0", m_req_valid,
               m_req_last, m_req_data, s_req_ready);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    m_req_ready = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      n_cmp++;
      if (m_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_no_chunk: m_req_valid=%b required 0 after reset", m_req_valid);
      end
    end
    m_req_ready = 1'b0;
    rq = rand_req(48'h5000, 28'd64);
    send_req(rq, "rst_next");
    drain(rq, 100, -1, 0, 99, "rst_next");
  endtask

  task automatic test_back_to_back;
    req_t rq;
    logic [47:0] va;
    logic [27:0] ln;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(3))
        0: va = 48'({$urandom(), $urandom()});
        1: va = 48'(($urandom_range(255) * P) - $urandom_range(64));
        2: va = 48'($urandom_range(255) * P);
        default: va = 48'($urandom_range(65535));
      endcase
      case ($urandom_range(3))
        0: ln = 28'($urandom_range(20000));
        1: ln = 28'($urandom_range(3) * P);
        2: ln = 28'($urandom_range(8));
        default: ln = 28'($urandom_range(9000));
      endcase
      rq = rand_req(va, ln);
      send_req(rq, "b2b");
      drain(rq, 60, -1, 0, 99, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
